demux_route: RTL and testbench



---
 rtl/demux_route.sv | 167 ++++++++++++++++
 tb/tb_demux_route.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_route.sv
// Registered 1-to-2 valid/ready demultiplexer: each accepted beat is steered
// (by cntrl, or alternating when mode=1) into one of two first-word-fall-through lane FIFOs.

module demux_route_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_ready,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_last;
    logic             w_empty;
    logic             w_pop;

    assign w_empty = (r_level == '0);
    assign w_pop   = !w_empty && i_ready;

    // NOTE: storage has no reset; the level counter alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_last   <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({i_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // An empty lane keeps presenting the last value it handed out.
    assign o_data  = w_empty ? r_last : r_mem[r_rd_ptr];
    assign o_valid = !w_empty;
    assign o_level = r_level;
    assign o_full  = (r_level == FULL_LVL);

    a_level_range: assert property (@(posedge clk) disable iff (!rst_n)
        r_level <= FULL_LVL);

    a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (o_valid && !i_ready) |=> (o_valid && o_data == $past(o_data)));

endmodule

module demux_route #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   cntrl,
    input  logic                   mode,
    output logic [WIDTH-1:0]       out1_data,
    output logic                   out1_valid,
    input  logic                   out1_ready,
    output logic [WIDTH-1:0]       out2_data,
    output logic                   out2_valid,
    input  logic                   out2_ready,
    output logic [$clog2(DEPTH):0] out1_level,
    output logic [$clog2(DEPTH):0] out2_level
);

    typedef enum logic {
        LANE1 = 1'b0,
        LANE2 = 1'b1
    } lane_e;

    lane_e w_target;
    logic  r_toggle;
    logic  w_full1;
    logic  w_full2;
    logic  w_accept;
    logic  w_push1;
    logic  w_push2;

    assign w_target = lane_e'(mode ? r_toggle : cntrl);

    // Readiness looks only at the target lane's own occupancy, never at in_valid
    // or at a pop in the same cycle, so a full lane cannot pass a beat through.
    assign in_ready = rst_n && ((w_target == LANE2) ? !w_full2 : !w_full1);
    assign w_accept = in_valid && in_ready;
    assign w_push1  = w_accept && (w_target == LANE1);
    assign w_push2  = w_accept && (w_target == LANE2);

    // Holding mode low for any clock restarts alternation at lane 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_toggle <= 1'b0;
        end else if (!mode) begin
            r_toggle <= 1'b0;
        end else if (w_accept) begin
            r_toggle <= ~r_toggle;
        end
    end

    demux_route_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lane1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push1),
        .i_data  (in_data),
        .i_ready (out1_ready),
        .o_data  (out1_data),
        .o_valid (out1_valid),
        .o_level (out1_level),
        .o_full  (w_full1)
    );

    demux_route_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lane2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push2),
        .i_data  (in_data),
        .i_ready (out2_ready),
        .o_data  (out2_data),
        .o_valid (out2_valid),
        .o_level (out2_level),
        .o_full  (w_full2)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push1 && w_full1) && !(w_push2 && w_full2));

    a_one_lane: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push1 && w_push2));

endmodule

// File: tb/tb_demux_route.sv
// Directed self-checking bench for demux_route (WIDTH=8, DEPTH=4).

module tb_demux_route;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       cntrl;
    logic       mode;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out2_data;
    logic       out2_valid;
    logic       out2_ready;
    logic [2:0] out1_level;
    logic [2:0] out2_level;

    int n_cmp = 0;
    int n_err = 0;

    demux_route #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cntrl      (cntrl),
        .mode       (mode),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .out1_level (out1_level),
        .out2_level (out2_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge; checks and new drives happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        cntrl = 1'b0; mode = 1'b0; out1_ready = 1'b1; out2_ready = 1'b1;
        #1;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++;
        repeat (3) tick();
        if ({out1_valid, out2_valid} !== 2'b00) begin n_err++; $display("FAIL rst_valids: got %b want 00", {out1_valid, out2_valid}); end
        n_cmp++;
        if ({out1_level, out2_level} !== 6'd0) begin n_err++; $display("FAIL rst_levels: got %0d/%0d want 0/0", out1_level, out2_level); end
        n_cmp++;
        if ({out1_data, out2_data} !== 16'h0000) begin n_err++; $display("FAIL rst_data: got %h/%h want 00/00", out1_data, out2_data); end
        n_cmp++;
        rst_n = 1'b1;
        #1;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
        n_cmp++;
        tick();
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
        n_cmp++;
    endtask

    task automatic test_steered();
        mode = 1'b0; out1_ready = 1'b1; out2_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h11; cntrl = 1'b0;
        tick();
        if ({out1_valid, out2_valid} !== 2'b10) begin n_err++; $display("FAIL steer1_valids: got %b want 10", {out1_valid, out2_valid}); end
        n_cmp++;
        if (out1_data !== 8'h11) begin n_err++; $display("FAIL steer1_data: got %h want 11", out1_data); end
        n_cmp++;
        in_data = 8'h22; cntrl = 1'b1;
        tick();
        if ({out1_valid, out2_valid} !== 2'b01) begin n_err++; $display("FAIL steer2_valids: got %b want 01", {out1_valid, out2_valid}); end
        n_cmp++;
        if (out2_data !== 8'h22) begin n_err++; $display("FAIL steer2_data: got %h want 22", out2_data); end
        n_cmp++;
        in_valid = 1'b0;
        tick();
        if ({out1_valid, out2_valid} !== 2'b00) begin n_err++; $display("FAIL steer_end_valids: got %b want 00", {out1_valid, out2_valid}); end
        n_cmp++;
        if ({out1_data, out2_data} !== 16'h1122) begin n_err++; $display("FAIL steer_hold_data: got %h/%h want 11/22", out1_data, out2_data); end
        n_cmp++;
    endtask

    task automatic test_alternate();
        logic [7:0] beats [5];
        logic [1:0] want_v [5];
        beats = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        want_v = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        mode = 1'b1; cntrl = 1'b0; out1_ready = 1'b1; out2_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = beats[i];
            tick();
            if ({out1_valid, out2_valid} !== want_v[i]) begin n_err++; $display("FAIL alt%0d_valids: got %b want %b", i, {out1_valid, out2_valid}, want_v[i]); end
            n_cmp++;
            if ((want_v[i] == 2'b10 ? out1_data : out2_data) !== beats[i]) begin n_err++; $display("FAIL alt%0d_data: got %h/%h want %h", i, out1_data, out2_data, beats[i]); end
            n_cmp++;
        end
        in_valid = 1'b0; mode = 1'b0;
        tick();
        mode = 1'b1; in_valid = 1'b1; in_data = 8'hB0;
        tick();
        in_valid = 1'b0;
        if ({out1_valid, out2_valid} !== 2'b10) begin n_err++; $display("FAIL alt_restart_valids: got %b want 10", {out1_valid, out2_valid}); end
        n_cmp++;
        if (out1_data !== 8'hB0) begin n_err++; $display("FAIL alt_restart_data: got %h want b0", out1_data); end
        n_cmp++;
        mode = 1'b0;
        tick();
    endtask

    task automatic test_lane_full();
        logic [7:0] drain [5];
        drain = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
        mode = 1'b0; cntrl = 1'b0; out1_ready = 1'b0; out2_ready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            in_valid = 1'b1; in_data = 8'(v);
            #1;
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_fill%0d_ready: got %b want 1", v, in_ready); end
            n_cmp++;
            tick();
            if (out1_level !== 3'(v)) begin n_err++; $display("FAIL full_fill%0d_level: got %0d want %0d", v, out1_level, v); end
            n_cmp++;
        end
        in_data = 8'h05;
        tick();
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_stall_ready: got %b want 0", in_ready); end
        n_cmp++;
        if ({out1_level, out2_level} !== {3'd4, 3'd0}) begin n_err++; $display("FAIL full_stall_levels: got %0d/%0d want 4/0", out1_level, out2_level); end
        n_cmp++;
        cntrl = 1'b1;
        #1;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_retarget_ready: got %b want 1", in_ready); end
        n_cmp++;
        tick();
        if ({out2_valid, out2_data, out2_level} !== {1'b1, 8'h05, 3'd1}) begin n_err++; $display("FAIL full_lane2_take: got v%b %h lvl%0d want v1 05 lvl1", out2_valid, out2_data, out2_level); end
        n_cmp++;
        // Lane 1 still full while its consumer pops: the input must wait a cycle.
        cntrl = 1'b0; in_data = 8'h06; out1_ready = 1'b1;
        #1;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_no_passthru: got %b want 0", in_ready); end
        n_cmp++;
        for (int i = 0; i < 5; i++) begin
            if (out1_valid !== 1'b1 || out1_data !== drain[i]) begin n_err++; $display("FAIL full_drain%0d: got v%b %h want v1 %h", i, out1_valid, out1_data, drain[i]); end
            n_cmp++;
            tick();
            if (i == 0) in_valid = 1'b1;
            else        in_valid = 1'b0;
        end
        if ({out1_valid, out1_level} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL full_drained: got v%b lvl%0d want v0 lvl0", out1_valid, out1_level); end
        n_cmp++;
        out2_ready = 1'b1;
        tick();
        if (out2_level !== 3'd0) begin n_err++; $display("FAIL full_lane2_drain: got %0d want 0", out2_level); end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        mode = 1'b0; cntrl = 1'b0; out1_ready = 1'b0; out2_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h30;
        tick();
        in_data = 8'h31;
        tick();
        if (out1_level !== 3'd2) begin n_err++; $display("FAIL wrap_prefill: got %0d want 2", out1_level); end
        n_cmp++;
        out1_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'h32 + 8'(i);
            if (out1_data !== 8'h30 + 8'(i)) begin n_err++; $display("FAIL wrap%0d_head: got %h want %h", i, out1_data, 8'h30 + 8'(i)); end
            n_cmp++;
            tick();
            if (out1_level !== 3'd2) begin n_err++; $display("FAIL wrap%0d_level: got %0d want 2", i, out1_level); end
            n_cmp++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (out1_data !== 8'h3A + 8'(i)) begin n_err++; $display("FAIL wrap_tail%0d: got %h want %h", i, out1_data, 8'h3A + 8'(i)); end
            n_cmp++;
            tick();
        end
        if (out1_valid !== 1'b0) begin n_err++; $display("FAIL wrap_empty: got %b want 0", out1_valid); end
        n_cmp++;
    endtask

    task automatic test_reset_mid();
        mode = 1'b0; out1_ready = 1'b0; out2_ready = 1'b0; in_valid = 1'b1;
        cntrl = 1'b0; in_data = 8'h41; tick();
        in_data = 8'h42; tick();
        in_data = 8'h43; tick();
        cntrl = 1'b1; in_data = 8'h44; tick();
        in_valid = 1'b0;
        if ({out1_level, out2_level} !== {3'd3, 3'd1}) begin n_err++; $display("FAIL mid_levels: got %0d/%0d want 3/1", out1_level, out2_level); end
        n_cmp++;
        #2 rst_n = 1'b0;
        #1;
        if ({out1_valid, out2_valid, in_ready} !== 3'b000) begin n_err++; $display("FAIL mid_async_valids: got %b want 000", {out1_valid, out2_valid, in_ready}); end
        n_cmp++;
        if ({out1_level, out2_level} !== 6'd0) begin n_err++; $display("FAIL mid_async_levels: got %0d/%0d want 0/0", out1_level, out2_level); end
        n_cmp++;
        if ({out1_data, out2_data} !== 16'h0000) begin n_err++; $display("FAIL mid_async_data: got %h/%h want 00/00", out1_data, out2_data); end
        n_cmp++;
        tick();
        rst_n = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;
        cntrl = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        #1;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rel_ready: got %b want 1", in_ready); end
        n_cmp++;
        tick();
        in_valid = 1'b0;
        if ({out1_valid, out2_valid, out2_data} !== {2'b01, 8'h5A}) begin n_err++; $display("FAIL mid_5a: got %b %h want 01 5a", {out1_valid, out2_valid}, out2_data); end
        n_cmp++;
        tick();
        if (out2_valid !== 1'b0) begin n_err++; $display("FAIL mid_5a_once: got %b want 0", out2_valid); end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_steered();
        test_alternate();
        test_lane_full();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
